fpga_ip_demo_cpu_jtag_ocimem: RTL and testbench

FPGA_IP_DEMO_CPU_JTAG_OCIMEM -- requirements
Module: fpga_ip_demo_cpu_jtag_ocimem

---
 rtl/fpga_ip_demo_cpu_ocimem_pkg.sv | 25 ++
 rtl/fpga_ip_demo_cpu_ocimem_ram.sv | 29 ++
 rtl/fpga_ip_demo_cpu_jtag_ocimem.sv | 162 ++++++++++++++++
 tb/tb_fpga_ip_demo_cpu_jtag_ocimem.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fpga_ip_demo_cpu_ocimem_pkg.sv
// Shared definitions for the debug on-chip memory: FSM states, default sizes
// and the bit positions of the fields carried in the captured JTAG word.
package fpga_ip_demo_cpu_ocimem_pkg;
  localparam int OCI_ADDR_W    = 8;
  localparam int OCI_DATA_W    = 32;
  localparam int JDO_W         = 38;
  localparam int JDO_CLR_RDY   = 35;
  localparam int JDO_CLR_ERR   = 34;
  localparam int JDO_SET_GO    = 33;
  localparam int JDO_ADDR_LSB  = 18;
  localparam int JDO_WDATA_LSB = 3;
  localparam int CTRL_RDY      = 0;
  localparam int CTRL_ERR      = 1;
  localparam int CTRL_GO       = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_J_RD,
    ST_J_RD_CAP,
    ST_J_WR,
    ST_AV_RD,
    ST_AV_RD_CAP,
    ST_AV_WR
  } ocimem_state_e;
endpackage

// File: rtl/fpga_ip_demo_cpu_ocimem_ram.sv
// Single-port debug RAM: synchronous one-cycle read, byte-enabled write.
// No reset, so contents survive a system reset.
module fpga_ip_demo_cpu_ocimem_ram
  import fpga_ip_demo_cpu_ocimem_pkg::*;
#(
  parameter int ADDR_W = OCI_ADDR_W,
  parameter int DATA_W = OCI_DATA_W
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [DATA_W/8-1:0]   i_be,
  output logic [DATA_W-1:0]     o_rdata
);
  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (i_be[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/fpga_ip_demo_cpu_jtag_ocimem.sv
// Debug on-chip memory: arbitrates JTAG and Avalon accesses onto one RAM port
// and hosts the debug-monitor ready/error/go handshake register.
module fpga_ip_demo_cpu_jtag_ocimem
  import fpga_ip_demo_cpu_ocimem_pkg::*;
#(
  parameter int ADDR_W = OCI_ADDR_W,
  parameter int DATA_W = OCI_DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [JDO_W-1:0]      jdo,
  input  logic                  take_action_ocimem_a,
  input  logic                  take_action_ocimem_b,
  input  logic                  take_no_action_ocimem_a,
  input  logic [ADDR_W:0]       av_address,
  input  logic                  av_read,
  input  logic                  av_write,
  input  logic [DATA_W-1:0]     av_writedata,
  input  logic [DATA_W/8-1:0]   av_byteenable,
  output logic [DATA_W-1:0]     av_readdata,
  output logic                  av_waitrequest,
  output logic [31:0]           MonDReg,
  output logic                  monitor_ready,
  output logic                  monitor_error,
  output logic                  monitor_go
);
  ocimem_state_e r_state, w_next;

  logic [ADDR_W-1:0]   r_jtag_addr;
  logic                r_wr_pending, r_rd_pending;
  logic [DATA_W-1:0]   r_wr_data, r_mon_d, r_rd_hold;
  logic                r_rdy, r_err, r_go;

  logic                w_busy, w_wr_acc, w_rd_acc, w_drop;
  logic                w_ram_we, w_waitreq, w_av_cap, w_ctrl_wr;
  logic [ADDR_W-1:0]   w_ram_addr;
  logic [DATA_W-1:0]   w_ram_wdata, w_ram_rdata, w_av_rdata, w_ctrl_word;
  logic [DATA_W/8-1:0] w_ram_be;
  logic                w_unused_jdo;

  assign w_unused_jdo = ^{jdo[JDO_W-1:JDO_CLR_RDY+1], jdo[JDO_WDATA_LSB-1:0]};

  // Only one JTAG transaction may be outstanding; a simultaneous write and
  // read pulse keeps the write and drops the read.
  assign w_busy   = r_wr_pending | r_rd_pending;
  assign w_wr_acc = take_action_ocimem_b & ~w_busy;
  assign w_rd_acc = take_no_action_ocimem_a & ~w_busy & ~take_action_ocimem_b;
  assign w_drop   = (take_action_ocimem_b & w_busy) |
                    (take_no_action_ocimem_a & (w_busy | take_action_ocimem_b));

  assign w_ctrl_word = {{(DATA_W-3){1'b0}}, r_go, r_err, r_rdy};
  assign w_ctrl_wr   = (r_state == ST_AV_WR) & av_address[ADDR_W] & av_byteenable[0];
  assign w_av_rdata  = av_address[ADDR_W] ? w_ctrl_word : w_ram_rdata;

  always_comb begin
    w_next      = r_state;
    w_ram_we    = 1'b0;
    w_ram_addr  = av_address[ADDR_W-1:0];
    w_ram_wdata = av_writedata;
    w_ram_be    = av_byteenable;
    w_waitreq   = 1'b1;
    w_av_cap    = 1'b0;
    unique case (r_state)
      // A JTAG pulse arriving this cycle is arbitrated immediately so it
      // beats an Avalon request presented in the same cycle.
      ST_IDLE: begin
        if (r_wr_pending | w_wr_acc)      w_next = ST_J_WR;
        else if (r_rd_pending | w_rd_acc) w_next = ST_J_RD;
        else if (av_write)                w_next = ST_AV_WR;
        else if (av_read)                 w_next = ST_AV_RD;
      end
      ST_J_WR: begin
        w_ram_we    = 1'b1;
        w_ram_addr  = r_jtag_addr;
        w_ram_wdata = r_wr_data;
        w_ram_be    = '1;
        w_next      = ST_IDLE;
      end
      ST_J_RD: begin
        w_ram_addr = r_jtag_addr;
        w_next     = ST_J_RD_CAP;
      end
      ST_J_RD_CAP: w_next = ST_IDLE;
      ST_AV_RD:    w_next = ST_AV_RD_CAP;
      ST_AV_RD_CAP: begin
        w_waitreq = 1'b0;
        w_av_cap  = 1'b1;
        w_next    = ST_IDLE;
      end
      ST_AV_WR: begin
        w_waitreq = 1'b0;
        w_ram_we  = ~av_address[ADDR_W];
        w_next    = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_jtag_addr  <= '0;
      r_wr_pending <= 1'b0;
      r_rd_pending <= 1'b0;
      r_wr_data    <= '0;
      r_mon_d      <= '0;
      r_rd_hold    <= '0;
      r_rdy        <= 1'b0;
      r_err        <= 1'b0;
      r_go         <= 1'b0;
    end else begin
      r_state <= w_next;

      if (take_action_ocimem_a)
        r_jtag_addr <= jdo[JDO_ADDR_LSB +: ADDR_W];
      else if (r_state == ST_J_WR || r_state == ST_J_RD_CAP)
        r_jtag_addr <= r_jtag_addr + 1'b1;

      if (w_wr_acc) begin
        r_wr_pending <= 1'b1;
        r_wr_data    <= jdo[JDO_WDATA_LSB +: DATA_W];
      end else if (r_state == ST_J_WR) begin
        r_wr_pending <= 1'b0;
      end

      if (w_rd_acc)                     r_rd_pending <= 1'b1;
      else if (r_state == ST_J_RD_CAP)  r_rd_pending <= 1'b0;

      if (r_state == ST_J_RD_CAP) r_mon_d   <= w_ram_rdata;
      if (w_av_cap)               r_rd_hold <= w_av_rdata;

      // Avalon wins every same-cycle conflict with the JTAG side.
      if (w_ctrl_wr & av_writedata[CTRL_RDY])            r_rdy <= 1'b1;
      else if (take_action_ocimem_a & jdo[JDO_CLR_RDY])  r_rdy <= 1'b0;

      if ((w_ctrl_wr & av_writedata[CTRL_ERR]) | w_drop) r_err <= 1'b1;
      else if (take_action_ocimem_a & jdo[JDO_CLR_ERR])  r_err <= 1'b0;

      if (w_ctrl_wr & av_writedata[CTRL_GO])             r_go <= 1'b0;
      else if (take_action_ocimem_a & jdo[JDO_SET_GO])   r_go <= 1'b1;
    end
  end

  fpga_ip_demo_cpu_ocimem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we & ~reset),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .i_be    (w_ram_be),
    .o_rdata (w_ram_rdata)
  );

  assign av_readdata    = w_av_cap ? w_av_rdata : r_rd_hold;
  assign av_waitrequest = w_waitreq;
  assign MonDReg        = r_mon_d;
  assign monitor_ready  = r_rdy;
  assign monitor_error  = r_err;
  assign monitor_go     = r_go;
endmodule

// File: tb/tb_fpga_ip_demo_cpu_jtag_ocimem.sv
// Directed bench for the debug on-chip memory: JTAG and Avalon paths,
// arbitration, address wrap, monitor flags and reset behaviour.
module tb_fpga_ip_demo_cpu_jtag_ocimem;
  import fpga_ip_demo_cpu_ocimem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_a, take_b, take_rd;
  logic [8:0]  av_address;
  logic        av_read, av_write;
  logic [31:0] av_writedata;
  logic [3:0]  av_byteenable;
  logic [31:0] av_readdata;
  logic        av_waitrequest;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error, monitor_go;

  int n_cmp = 0;
  int n_err = 0;

  fpga_ip_demo_cpu_jtag_ocimem dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_a),
    .take_action_ocimem_b    (take_b),
    .take_no_action_ocimem_a (take_rd),
    .av_address              (av_address),
    .av_read                 (av_read),
    .av_write                (av_write),
    .av_writedata            (av_writedata),
    .av_byteenable           (av_byteenable),
    .av_readdata             (av_readdata),
    .av_waitrequest          (av_waitrequest),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .monitor_go              (monitor_go)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_a(input logic [7:0] addr, input logic clr_rdy,
                         input logic clr_err, input logic set_go);
    jdo = '0; jdo[25:18] = addr; jdo[35] = clr_rdy; jdo[34] = clr_err; jdo[33] = set_go;
    take_a = 1'b1; tick(); take_a = 1'b0; jdo = '0;
  endtask

  task automatic pulse_b(input logic [31:0] d);
    jdo = '0; jdo[34:3] = d; take_b = 1'b1; tick(); take_b = 1'b0; jdo = '0;
  endtask

  task automatic pulse_rd();
    take_rd = 1'b1; tick(); take_rd = 1'b0;
  endtask

  // cyc = cycle (1-based from assertion) in which waitrequest was low; 0 = timeout
  task automatic av_xfer(input logic wr, input logic [8:0] addr, input logic [31:0] d,
                         input logic [3:0] be, output int cyc, output logic [31:0] rd);
    av_address = addr; av_writedata = d; av_byteenable = be;
    av_write = wr; av_read = ~wr; cyc = 0; rd = '0;
    for (int i = 1; i <= 20; i++) begin
      if (av_waitrequest === 1'b0) begin cyc = i; rd = av_readdata; break; end
      tick();
    end
    tick(); av_write = 1'b0; av_read = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(2);
    n_cmp++; if (av_waitrequest !== 1'b1) begin n_err++; $display("FAIL reset_waitreq: got %b want 1", av_waitrequest); end
    reset = 1'b0; tick();
    n_cmp++; if (av_waitrequest !== 1'b1) begin n_err++; $display("FAIL idle_waitreq: got %b want 1", av_waitrequest); end
    n_cmp++; if (MonDReg !== 32'h0) begin n_err++; $display("FAIL reset_mondreg: got %h want 0", MonDReg); end
    n_cmp++; if (av_readdata !== 32'h0) begin n_err++; $display("FAIL reset_readdata: got %h want 0", av_readdata); end
    n_cmp++; if ({monitor_go, monitor_error, monitor_ready} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: got %b want 000", {monitor_go, monitor_error, monitor_ready}); end
    n_cmp++; if (dut.r_jtag_addr !== 8'h00) begin n_err++; $display("FAIL reset_jaddr: got %h want 00", dut.r_jtag_addr); end
  endtask

  task automatic test_jtag_rw();
    pulse_a(8'h10, 1'b0, 1'b0, 1'b0);
    pulse_b(32'hDEADBEEF);
    tick(3);
    n_cmp++; if (dut.r_jtag_addr !== 8'h11) begin n_err++; $display("FAIL jwr_incr: got %h want 11", dut.r_jtag_addr); end
    pulse_a(8'h10, 1'b0, 1'b0, 1'b0);
    pulse_rd();
    tick(4);
    n_cmp++; if (MonDReg !== 32'hDEADBEEF) begin n_err++; $display("FAIL jrd_data: got %h want deadbeef", MonDReg); end
    n_cmp++; if (dut.r_jtag_addr !== 8'h11) begin n_err++; $display("FAIL jrd_incr: got %h want 11", dut.r_jtag_addr); end
    n_cmp++; if (monitor_error !== 1'b0) begin n_err++; $display("FAIL jrw_noerr: got %b want 0", monitor_error); end
  endtask

  task automatic test_avalon();
    int c; logic [31:0] r;
    av_xfer(1'b1, 9'h005, 32'h0000_0000, 4'b1111, c, r);
    n_cmp++; if (c !== 2) begin n_err++; $display("FAIL av_wr_lat: got %0d want 2", c); end
    av_xfer(1'b1, 9'h005, 32'h1234_5678, 4'b0011, c, r);
    av_xfer(1'b0, 9'h005, 32'h0, 4'b1111, c, r);
    n_cmp++; if (c !== 3) begin n_err++; $display("FAIL av_rd_lat: got %0d want 3", c); end
    n_cmp++; if (r !== 32'h0000_5678) begin n_err++; $display("FAIL av_rd_be: got %h want 00005678", r); end
    tick(2);
    n_cmp++; if (av_readdata !== 32'h0000_5678) begin n_err++; $display("FAIL av_rd_hold: got %h want 00005678", av_readdata); end
    av_xfer(1'b1, 9'h005, 32'hAABB_CCDD, 4'b1000, c, r);
    av_xfer(1'b0, 9'h005, 32'h0, 4'b1111, c, r);
    n_cmp++; if (r !== 32'hAA00_5678) begin n_err++; $display("FAIL av_rd_be3: got %h want aa005678", r); end
  endtask

  task automatic test_back_to_back();
    int c; logic [31:0] r;
    pulse_a(8'h20, 1'b0, 1'b0, 1'b0);
    jdo = '0; jdo[34:3] = 32'hCAFEF00D; take_b = 1'b1;
    av_address = 9'h020; av_byteenable = 4'b1111; av_read = 1'b1; av_write = 1'b0;
    c = 0; r = '0;
    for (int i = 1; i <= 20; i++) begin
      if (av_waitrequest === 1'b0) begin c = i; r = av_readdata; break; end
      tick(); take_b = 1'b0; jdo = '0;
    end
    tick(); av_read = 1'b0;
    // JTAG write runs first, so the read sees the fresh word and is stalled past 3 cycles
    n_cmp++; if (r !== 32'hCAFEF00D) begin n_err++; $display("FAIL b2b_order: got %h want cafef00d", r); end
    n_cmp++; if (c < 4 || c > 5) begin n_err++; $display("FAIL b2b_stall: got %0d want 4..5", c); end
  endtask

  task automatic test_wrap_drop();
    int c; logic [31:0] r;
    pulse_a(8'hFF, 1'b0, 1'b0, 1'b0);
    pulse_b(32'h1111_1111);
    tick(3);
    n_cmp++; if (dut.r_jtag_addr !== 8'h00) begin n_err++; $display("FAIL wrap_addr: got %h want 00", dut.r_jtag_addr); end
    pulse_b(32'h2222_2222);
    pulse_b(32'h3333_3333);
    tick(3);
    n_cmp++; if (monitor_error !== 1'b1) begin n_err++; $display("FAIL drop_err: got %b want 1", monitor_error); end
    n_cmp++; if (dut.r_jtag_addr !== 8'h01) begin n_err++; $display("FAIL drop_addr: got %h want 01", dut.r_jtag_addr); end
    av_xfer(1'b0, 9'h0FF, 32'h0, 4'b1111, c, r);
    n_cmp++; if (r !== 32'h1111_1111) begin n_err++; $display("FAIL wrap_ff: got %h want 11111111", r); end
    av_xfer(1'b0, 9'h000, 32'h0, 4'b1111, c, r);
    n_cmp++; if (r !== 32'h2222_2222) begin n_err++; $display("FAIL wrap_00: got %h want 22222222", r); end
    pulse_a(8'h00, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (monitor_error !== 1'b0) begin n_err++; $display("FAIL err_clear: got %b want 0", monitor_error); end
  endtask

  task automatic test_ctrl();
    int c; logic [31:0] r;
    pulse_a(8'h00, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (monitor_go !== 1'b1) begin n_err++; $display("FAIL go_set: got %b want 1", monitor_go); end
    av_xfer(1'b1, 9'h100, 32'h0000_0005, 4'b1111, c, r);
    n_cmp++; if ({monitor_go, monitor_ready} !== 2'b01) begin
      n_err++; $display("FAIL ctrl_wr: got go,rdy=%b want 01", {monitor_go, monitor_ready}); end
    av_xfer(1'b0, 9'h100, 32'h0, 4'b1111, c, r);
    n_cmp++; if (r !== 32'h0000_0001) begin n_err++; $display("FAIL ctrl_rd: got %h want 00000001", r); end
    av_xfer(1'b1, 9'h100, 32'h0000_0002, 4'b1110, c, r);
    n_cmp++; if (monitor_error !== 1'b0) begin n_err++; $display("FAIL ctrl_be_gate: got %b want 0", monitor_error); end
  endtask

  task automatic test_conflict();
    pulse_a(8'h00, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (monitor_ready !== 1'b0) begin n_err++; $display("FAIL rdy_clear: got %b want 0", monitor_ready); end
    av_address = 9'h100; av_writedata = 32'h1; av_byteenable = 4'b1111; av_write = 1'b1;
    tick();
    jdo = '0; jdo[35] = 1'b1; take_a = 1'b1;
    tick(); take_a = 1'b0; av_write = 1'b0; jdo = '0;
    n_cmp++; if (monitor_ready !== 1'b1) begin n_err++; $display("FAIL rdy_conflict: got %b want 1", monitor_ready); end
    pulse_a(8'h00, 1'b0, 1'b0, 1'b1);
    av_writedata = 32'h4; av_write = 1'b1;
    tick();
    jdo = '0; jdo[33] = 1'b1; take_a = 1'b1;
    tick(); take_a = 1'b0; av_write = 1'b0; jdo = '0;
    n_cmp++; if (monitor_go !== 1'b0) begin n_err++; $display("FAIL go_conflict: got %b want 0", monitor_go); end
  endtask

  task automatic test_reset_mid();
    int c; logic [31:0] r;
    av_address = 9'h005; av_byteenable = 4'b1111; av_read = 1'b1;
    tick();
    reset = 1'b1; #1;
    n_cmp++; if (av_waitrequest !== 1'b1) begin n_err++; $display("FAIL rst_mid_wait: got %b want 1", av_waitrequest); end
    n_cmp++; if (dut.r_state !== ST_IDLE) begin n_err++; $display("FAIL rst_mid_state: got %0d want %0d", dut.r_state, ST_IDLE); end
    n_cmp++; if (monitor_ready !== 1'b0) begin n_err++; $display("FAIL rst_mid_rdy: got %b want 0", monitor_ready); end
    tick(); av_read = 1'b0; reset = 1'b0; tick();
    av_writedata = 32'hFFFF_FFFF; av_write = 1'b1;
    tick();
    reset = 1'b1; #1;
    tick(); reset = 1'b0; av_write = 1'b0; tick();
    av_xfer(1'b0, 9'h005, 32'h0, 4'b1111, c, r);
    n_cmp++; if (r !== 32'hAA00_5678) begin n_err++; $display("FAIL rst_no_write: got %h want aa005678", r); end
  endtask

  initial begin
    reset = 1'b1; jdo = '0; take_a = 1'b0; take_b = 1'b0; take_rd = 1'b0;
    av_address = '0; av_read = 1'b0; av_write = 1'b0; av_writedata = '0; av_byteenable = '0;
    test_reset();
    test_jtag_rw();
    test_avalon();
    test_back_to_back();
    test_wrap_drop();
    test_ctrl();
    test_conflict();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
